key_debounce: RTL and testbench

KEY_DEBOUNCE -- requirements
Module: key_debounce

---
 rtl/led_pkg.sv | 25 ++
 rtl/ms_tick.sv | 43 ++++
 rtl/key_debounce.sv | 160 ++++++++++++++++
 tb/tb_key_debounce.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared definitions for the push-button debouncer and the LED driver.
// Holds the debouncer FSM state encoding, the ms-tick / ms-counter widths
// and the packed pulse-event record used for the registered output pulses.
package led_pkg;

   // Tick prescaler width: covers clock rates up to ~16 GHz in kHz units.
   localparam int unsigned TICK_CNT_W = 24;
   // Millisecond counter width: long-press times up to 65535 ms.
   localparam int unsigned MS_CNT_W   = 16;
   localparam int unsigned STATE_W    = 3;

   localparam logic [STATE_W-1:0] ST_IDLE       = 3'd0;
   localparam logic [STATE_W-1:0] ST_PRESS_DB   = 3'd1;
   localparam logic [STATE_W-1:0] ST_HELD       = 3'd2;
   localparam logic [STATE_W-1:0] ST_LONG_HELD  = 3'd3;
   localparam logic [STATE_W-1:0] ST_RELEASE_DB = 3'd4;

   // One-cycle key events; at most one field is ever set.
   typedef struct packed {
      logic press_p;
      logic release_p;
      logic long_p;
   } key_evt_t;

endpackage

// File: rtl/ms_tick.sv
// Free-running millisecond tick generator.
// Counts 0..P_CLK_KHZ-1 and raises o_tick for the one cycle in which the
// count equals P_CLK_KHZ-1, then wraps to 0.
// Ports:
//   i_clk  - clock
//   i_rst  - synchronous active-high reset (counter and tick to 0)
//   o_tick - registered one-cycle pulse once per millisecond
module ms_tick
   import led_pkg::*;
#(
   parameter int unsigned P_CLK_KHZ = 5000
) (
   input  logic i_clk,
   input  logic i_rst,
   output logic o_tick
);

   localparam logic [TICK_CNT_W-1:0] TICK_LAST = TICK_CNT_W'(P_CLK_KHZ - 1);

   logic [TICK_CNT_W-1:0] cnt;
   logic [TICK_CNT_W-1:0] cnt_nxt;

   // Next count with wrap at the terminal value.
   always_comb begin
      cnt_nxt = cnt + TICK_CNT_W'(1);
      if (cnt == TICK_LAST) begin
         cnt_nxt = '0;
      end
   end

   // Tick is registered from the next count so it is high exactly while
   // the count sits at its terminal value.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cnt    <= '0;
         o_tick <= 1'b0;
      end else begin
         cnt    <= cnt_nxt;
         o_tick <= (cnt_nxt == TICK_LAST);
      end
   end

endmodule

// File: rtl/key_debounce.sv
// Push-button debouncer with press, release and long-press detection.
// The raw pin is synchronised, normalised to 1 = pressed, and qualified by
// an FSM that requires P_DEBOUNCE_MS of stable level (counted in free-running
// ms ticks) before accepting a press or release. A press held P_LONG_MS after
// acceptance raises a single long-press pulse.
// At chip level o_key_press drives the LED driver mode step and o_key_long
// drives the LED driver mode reset.
// Ports:
//   i_clk         - clock
//   i_rst         - synchronous active-high reset
//   i_key         - raw asynchronous push-button pin
//   o_key_level   - debounced pressed state, 1 = pressed
//   o_key_press   - one-cycle pulse on accepted press
//   o_key_release - one-cycle pulse on accepted release
//   o_key_long    - one-cycle pulse after P_LONG_MS of accepted hold
module key_debounce
   import led_pkg::*;
#(
   parameter int unsigned P_CLK_KHZ     = 5000,
   parameter int unsigned P_DEBOUNCE_MS = 20,
   parameter int unsigned P_LONG_MS     = 1000,
   parameter logic        P_KEY_ACTIVE  = 1'b0
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_key,
   output logic o_key_level,
   output logic o_key_press,
   output logic o_key_release,
   output logic o_key_long
);

   localparam logic [MS_CNT_W-1:0] DB_LAST   = MS_CNT_W'(P_DEBOUNCE_MS - 1);
   localparam logic [MS_CNT_W-1:0] LONG_LAST = MS_CNT_W'(P_LONG_MS - 1);
   localparam logic [1:0]          SYNC_REL  = {2{~P_KEY_ACTIVE}};

   logic [1:0]          sync_q;
   logic                key_s;
   logic                tick;
   logic [STATE_W-1:0]  state;
   logic [STATE_W-1:0]  state_nxt;
   logic [MS_CNT_W-1:0] ms_cnt;
   logic                long_flag;
   logic                long_flag_nxt;
   logic                level_q;
   logic                level_nxt;
   key_evt_t            evt_q;
   key_evt_t            evt_nxt;
   logic                db_done;
   logic                long_done;

   // Two-flop synchroniser, reset to the released pin level.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         sync_q <= SYNC_REL;
      end else begin
         sync_q <= {sync_q[0], i_key};
      end
   end

   assign key_s = (sync_q[1] == P_KEY_ACTIVE);

   ms_tick #(
      .P_CLK_KHZ (P_CLK_KHZ)
   ) u_ms_tick (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .o_tick (tick)
   );

   // Terminal conditions fire on the tick that would bring ms_cnt to the target.
   assign db_done   = tick && (ms_cnt == DB_LAST);
   assign long_done = tick && (ms_cnt == LONG_LAST);

   // Millisecond counter: clears on any state change, saturates at all-ones.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         ms_cnt <= '0;
      end else if (state_nxt != state) begin
         ms_cnt <= '0;
      end else if (tick && (ms_cnt != '1)) begin
         ms_cnt <= ms_cnt + MS_CNT_W'(1);
      end
   end

   // FSM state and registered outputs.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state     <= ST_IDLE;
         long_flag <= 1'b0;
         level_q   <= 1'b0;
         evt_q     <= '0;
      end else begin
         state     <= state_nxt;
         long_flag <= long_flag_nxt;
         level_q   <= level_nxt;
         evt_q     <= evt_nxt;
      end
   end

   // Next state and output decode; key_s changes are tested before the
   // terminal tick so a bounce always cancels acceptance.
   always_comb begin
      state_nxt     = state;
      long_flag_nxt = long_flag;
      level_nxt     = level_q;
      evt_nxt       = '0;
      case (state)
         ST_IDLE: begin
            if (key_s) begin
               state_nxt = ST_PRESS_DB;
            end
         end
         ST_PRESS_DB: begin
            if (!key_s) begin
               state_nxt = ST_IDLE;
            end else if (db_done) begin
               state_nxt       = ST_HELD;
               level_nxt       = 1'b1;
               evt_nxt.press_p = 1'b1;
            end
         end
         ST_HELD: begin
            if (!key_s) begin
               state_nxt = ST_RELEASE_DB;
            end else if (long_done) begin
               state_nxt      = ST_LONG_HELD;
               long_flag_nxt  = 1'b1;
               evt_nxt.long_p = 1'b1;
            end
         end
         ST_LONG_HELD: begin
            if (!key_s) begin
               state_nxt = ST_RELEASE_DB;
            end
         end
         ST_RELEASE_DB: begin
            if (key_s) begin
               state_nxt = long_flag ? ST_LONG_HELD : ST_HELD;
            end else if (db_done) begin
               state_nxt         = ST_IDLE;
               level_nxt         = 1'b0;
               long_flag_nxt     = 1'b0;
               evt_nxt.release_p = 1'b1;
            end
         end
         default: begin
            state_nxt     = ST_IDLE;
            level_nxt     = 1'b0;
            long_flag_nxt = 1'b0;
         end
      endcase
   end

   assign o_key_level   = level_q;
   assign o_key_press   = evt_q.press_p;
   assign o_key_release = evt_q.release_p;
   assign o_key_long    = evt_q.long_p;

endmodule

// File: tb/tb_key_debounce.sv
// Self-checking bench for key_debounce at 4 kHz clock, 3 ms debounce,
// 10 ms long press, active-low key. Expected pulses are queued when stimulus
// is applied and popped by a negedge monitor as the DUT emits them.
module tb_key_debounce;

   localparam int K_PRESS = 0;
   localparam int K_LONG  = 1;
   localparam int K_REL   = 2;
   localparam int NVEC    = 6;

   logic clk;
   logic i_rst;
   logic i_key;
   logic o_key_level;
   logic o_key_press;
   logic o_key_release;
   logic o_key_long;

   int errors;
   int checks;
   int cyc;
   int sb[$];
   bit sb_on;
   bit expect_press;
   bit long_since_press;
   int n_press;
   int n_long;
   int n_rel;
   int last_press_cyc;
   int last_long_cyc;
   int last_rel_cyc;
   int kind;
   logic prev_p;
   logic prev_l;
   logic prev_r;

   typedef struct {
      string name;
      int    hold;
      int    gap;
      bit    exp_p;
      bit    exp_l;
      bit    exp_r;
   } vec_t;

   vec_t vecs[NVEC];

   key_debounce #(
      .P_CLK_KHZ     (4),
      .P_DEBOUNCE_MS (3),
      .P_LONG_MS     (10),
      .P_KEY_ACTIVE  (1'b0)
   ) dut (
      .i_clk         (clk),
      .i_rst         (i_rst),
      .i_key         (i_key),
      .o_key_level   (o_key_level),
      .o_key_press   (o_key_press),
      .o_key_release (o_key_release),
      .o_key_long    (o_key_long)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      cyc = 0;
      forever begin
         @(posedge clk);
         cyc = cyc + 1;
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chk_rng(input string name, input int act, input int lo, input int hi);
      checks = checks + 1;
      if (act < lo || act > hi) begin
         errors = errors + 1;
         $display("FAIL %s: got %0d, required %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Pulse monitor: protocol rules on every pulse, plus scoreboard ordering.
   initial begin
      prev_p = 1'b0;
      prev_l = 1'b0;
      prev_r = 1'b0;
      forever begin
         @(negedge clk);
         if (i_rst === 1'b1) begin
            expect_press     = 1'b1;
            long_since_press = 1'b0;
         end
         if (o_key_press === 1'b1 || o_key_long === 1'b1 || o_key_release === 1'b1) begin
            chk("pulse_onehot", $countones({o_key_press, o_key_long, o_key_release}), 1);
            if (o_key_press === 1'b1) begin
               kind = K_PRESS;
               chk("press_width", 32'(prev_p), 0);
               chk("press_order", 32'(expect_press), 1);
               chk("level_at_press", 32'(o_key_level), 1);
               expect_press     = 1'b0;
               long_since_press = 1'b0;
               n_press          = n_press + 1;
               last_press_cyc   = cyc;
            end else if (o_key_long === 1'b1) begin
               kind = K_LONG;
               chk("long_width", 32'(prev_l), 0);
               chk("long_repeat", 32'(long_since_press), 0);
               chk("level_at_long", 32'(o_key_level), 1);
               long_since_press = 1'b1;
               n_long           = n_long + 1;
               last_long_cyc    = cyc;
            end else begin
               kind = K_REL;
               chk("release_width", 32'(prev_r), 0);
               chk("release_order", 32'(expect_press), 0);
               chk("level_at_release", 32'(o_key_level), 0);
               expect_press = 1'b1;
               n_rel        = n_rel + 1;
               last_rel_cyc = cyc;
            end
            if (sb_on) begin
               if (sb.size() == 0) begin
                  checks = checks + 1;
                  errors = errors + 1;
                  $display("FAIL sb_unexpected: got pulse kind %0d, required none (cycle %0d)", kind, cyc);
               end else begin
                  chk("sb_kind", kind, sb.pop_front());
               end
            end
         end
         prev_p = o_key_press;
         prev_l = o_key_long;
         prev_r = o_key_release;
      end
   end

   initial begin
      int c0;
      int c1;
      int rel_before;

      errors           = 0;
      checks           = 0;
      sb_on            = 1'b1;
      expect_press     = 1'b1;
      long_since_press = 1'b0;
      n_press          = 0;
      n_long           = 0;
      n_rel            = 0;
      last_press_cyc   = 0;
      last_long_cyc    = 0;
      last_rel_cyc     = 0;
      i_rst            = 1'b1;
      i_key            = 1'b1;

      // name, hold cycles, released gap, expected press / long / release
      vecs[0] = '{"short_8",  8,   30, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{"hold_40",  40,  30, 1'b1, 1'b0, 1'b1};
      vecs[2] = '{"hold_16",  16,  30, 1'b1, 1'b0, 1'b1};
      vecs[3] = '{"hold_30",  30,  30, 1'b1, 1'b0, 1'b1};
      vecs[4] = '{"hold_240", 240, 30, 1'b1, 1'b1, 1'b1};
      vecs[5] = '{"short_5",  5,   30, 1'b0, 1'b0, 1'b0};

      // Reset state
      step(3);
      chk("rst_level", 32'(o_key_level), 0);
      chk("rst_press", 32'(o_key_press), 0);
      chk("rst_release", 32'(o_key_release), 0);
      chk("rst_long", 32'(o_key_long), 0);
      i_rst = 1'b0;
      step(20);
      chk("idle_level", 32'(o_key_level), 0);

      // Table-driven press/release vectors
      for (int i = 0; i < NVEC; i++) begin
         if (vecs[i].exp_p) sb.push_back(K_PRESS);
         if (vecs[i].exp_l) sb.push_back(K_LONG);
         if (vecs[i].exp_r) sb.push_back(K_REL);
         c0    = cyc;
         i_key = 1'b0;
         step(vecs[i].hold);
         chk({vecs[i].name, "_level_held"}, 32'(o_key_level), 32'(vecs[i].exp_p));
         c1    = cyc;
         i_key = 1'b1;
         step(vecs[i].gap);
         chk({vecs[i].name, "_sb_drained"}, sb.size(), 0);
         chk({vecs[i].name, "_level_end"}, 32'(o_key_level), 0);
         if (vecs[i].exp_p) chk_rng({vecs[i].name, "_press_lat"}, last_press_cyc - (c0 + 1), 11, 14);
         if (vecs[i].exp_l) chk_rng({vecs[i].name, "_long_lat"}, last_long_cyc - last_press_cyc, 37, 40);
         if (vecs[i].exp_r) chk_rng({vecs[i].name, "_rel_lat"}, last_rel_cyc - (c1 + 1), 11, 14);
         sb.delete();
      end

      // Single-cycle release glitches every 5 cycles while held
      sb.push_back(K_PRESS);
      i_key = 1'b0;
      step(20);
      chk("glitch_press_seen", sb.size(), 0);
      rel_before = n_rel;
      for (int g = 0; g < 12; g++) begin
         step(4);
         i_key = 1'b1;
         step(1);
         i_key = 1'b0;
      end
      chk("glitch_level", 32'(o_key_level), 1);
      chk("glitch_no_release", n_rel - rel_before, 0);
      sb.push_back(K_REL);
      i_key = 1'b1;
      step(30);
      chk("glitch_release_seen", sb.size(), 0);
      chk("glitch_level_end", 32'(o_key_level), 0);
      sb.delete();

      // Reset while in long-held, key still down
      sb.push_back(K_PRESS);
      sb.push_back(K_LONG);
      i_key = 1'b0;
      step(70);
      chk("lrst_long_seen", sb.size(), 0);
      chk("lrst_level_pre", 32'(o_key_level), 1);
      rel_before = n_rel;
      i_rst = 1'b1;
      step(1);
      chk("lrst_level", 32'(o_key_level), 0);
      chk("lrst_press", 32'(o_key_press), 0);
      chk("lrst_long", 32'(o_key_long), 0);
      chk("lrst_release", 32'(o_key_release), 0);
      i_rst = 1'b0;
      sb.push_back(K_PRESS);
      step(25);
      chk("lrst_repress_seen", sb.size(), 0);
      chk("lrst_level_post", 32'(o_key_level), 1);
      chk("lrst_no_release", n_rel - rel_before, 0);
      sb.push_back(K_REL);
      i_key = 1'b1;
      step(30);
      chk("lrst_release_seen", sb.size(), 0);
      sb.delete();

      // Random bounce: monitor enforces width, exclusivity and alternation
      sb_on = 1'b0;
      for (int r = 0; r < 60; r++) begin
         i_key = 1'($urandom_range(0, 1));
         step(int'($urandom_range(1, 40)));
      end
      i_key = 1'b1;
      step(40);
      chk("rand_level_end", 32'(o_key_level), 0);
      chk("rand_ends_released", 32'(expect_press), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
